mdu_hilo: RTL and testbench

- Iterative multiply/divide unit owning the architectural HI/LO registers of the MIPS core.
- Sits beside and downstream of the ALU in the execute stage. It consumes the same op1/op2 operands the ALU receives and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Drives the high/low values read by MFHI/MFLO.
- Asserts busy so the pipeline stalls any HI/LO-dependent instruction until the result is written.

---
 rtl/mdu_hilo.sv | 174 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Optional MADD/MADDU (md_op 110/111) accumulate into HI/LO when MDU_MADD_EN is defined.
module mdu_hilo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               dneg_q, dneg_d;
  logic [WIDTH-1:0]   high_q, high_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic               done_q, done_d;

  logic               is_div, is_signed, op_ok;
  logic [WIDTH-1:0]   mag1, mag2, addend;
  logic [WIDTH:0]     mul_sum, div_rsh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign is_div    = (op_q[2:1] == 2'b01);
  assign is_signed = ~op_q[0];
  assign mag1      = (is_signed && op1_q[WIDTH-1]) ? -op1_q : op1_q;
  assign mag2      = (is_signed && op2_q[WIDTH-1]) ? -op2_q : op2_q;

  // Multiply: acc = {partial high, remaining multiplier bits}; add then shift right.
  assign addend  = acc_q[0] ? opb_q : '0;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract the divisor.
  assign div_rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = (div_rsh >= {1'b0, opb_q});
  assign div_diff = div_rsh[WIDTH-1:0] - opb_q;

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quot = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = dneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_MADD_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~md_op[2];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    high_d  = high_q;
    low_d   = low_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (md_op == 3'b100) begin
            high_d = op1;
          end else if (md_op == 3'b101) begin
            low_d = op1;
          end else if (op_ok) begin
            op_d    = md_op;
            op1_d   = op1;
            op2_d   = op2;
            state_d = StPrep;
          end
        end
      end
      StPrep: begin
        if (is_div) begin
          acc_d = {{WIDTH{1'b0}}, mag1};
          opb_d = mag2;
        end else begin
          acc_d = {{WIDTH{1'b0}}, mag2};
          opb_d = mag1;
        end
        neg_d   = is_signed & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
        dneg_d  = is_signed & op1_q[WIDTH-1];
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (is_div) begin
          acc_d = {(div_ge ? div_diff : div_rsh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (is_div) begin
          low_d  = quot;
          high_d = rem;
        end else begin
`ifdef MDU_MADD_EN
          if (op_q[2]) {high_d, low_d} = {high_q, low_q} + prod;
          else         {high_d, low_d} = prod;
`else
          {high_d, low_d} = prod;
`endif
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      high_q  <= high_d;
      low_q   <= low_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign high = high_q;
  assign low  = low_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: arithmetic reference model, queue of expected HI/LO results.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] high, low;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .op1   (op1),
    .op2   (op2),
    .busy  (busy),
    .done  (done),
    .high  (high),
    .low   (low)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h required 0x%016h", name, act, req);
    end
  endtask

  // Reference: {HI, LO} after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: r = 64'(sa * sb);
      3'b001: r = {32'h0, a} * {32'h0, b};
      3'b010: begin
        if (b == 32'h0) begin
          r = {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      3'b011: r = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
`ifdef MDU_MADD_EN
      3'b110: r = {hi, lo} + 64'(sa * sb);
      3'b111: r = {hi, lo} + {32'h0, a} * {32'h0, b};
`endif
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required no result pending (hilo 0x%08h_%08h)",
                 high, low);
      end else begin
        check("result_hilo", {high, low}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [63:0] e;
    int          n;
    e = model(op, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; md_op = op; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0; op1 = $urandom; op2 = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
    check("hilo_held_while_busy", {high, low}, {m_hi, m_lo});
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 5) begin
        start = 1'b1; md_op = 3'b100; op1 = 32'hDEAD_BEEF;
      end else if (inject && n == 6) begin
        start = 1'b1; md_op = 3'b001; op1 = 32'd7; op2 = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 64'(n), 64'd34);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic move(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; md_op = to_hi ? 3'b100 : 3'b101; op1 = v; op2 = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (to_hi) m_hi = v;
    else       m_lo = v;
    check("move_value", {high, low}, {m_hi, m_lo});
    check("move_no_busy", 64'(busy), 64'd0);
    check("move_no_done", 64'(done), 64'd0);
  endtask

  task automatic reserved_op();
    @(negedge clk);
    start = 1'b1; md_op = {2'b11, 1'($urandom_range(0, 1))}; op1 = $urandom; op2 = $urandom;
    @(negedge clk);
    start = 1'b0;
    check("reserved_no_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check("reserved_hilo", {high, low}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; md_op = 3'b000; op1 = '0; op2 = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {high, low}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max", {high, low}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    check("mult_neg", {high, low}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check("div_neg", {high, low}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'b011, 32'h0000_1234, 32'h0, 1'b0);
    check("divu_by_zero", {high, low}, 64'h0000_1234_FFFF_FFFF);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_overflow", {high, low}, 64'h0000_0000_8000_0000);
    run_op(3'b010, 32'hFFFF_FF00, 32'h0, 1'b0);
    check("div_neg_by_zero", {high, low}, 64'hFFFF_FF00_0000_0001);

    move(1'b1, 32'hCAFE_BABE);
    move(1'b0, 32'h1234_5678);
    run_op(3'b001, 32'd2, 32'd3, 1'b1);
    check("multu_ignore_start", {high, low}, 64'd6);

`ifdef MDU_MADD_EN
    run_op(3'b110, 32'hFFFF_FFFF, 32'd10, 1'b0);
    run_op(3'b111, 32'hFFFF_FFFF, 32'd2, 1'b0);
`else
    reserved_op();
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'(b >> $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) begin
        move(1'($urandom_range(0, 1)), a);
      end else begin
`ifdef MDU_MADD_EN
        op = 3'($urandom_range(0, 5));
        if (op[2]) op = {2'b11, op[0]};
`else
        op = 3'($urandom_range(0, 3));
`endif
        run_op(op, a, b, 1'b0);
      end
    end

    move(1'b1, 32'h1111_1111);
    move(1'b0, 32'h2222_2222);
    @(negedge clk);
    start = 1'b1; md_op = 3'b011; op1 = 32'h0F0F_0F0F; op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {high, low}, 64'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b001, 32'd5, 32'd5, 1'b0);
    check("multu_after_reset", {high, low}, 64'd25);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
